// File: rtl/cdc_pkg.sv
// Shared types for the multi-channel pulse source controller.
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    WAIT = 2'd3
  } ch_state_e;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/cdc_pulse_src_ch.sv
// One channel: ack synchronizer, pending-pulse counter, sticky overflow and handshake FSM.
// state | meaning: IDLE no open transfer | REQ req high, awaiting ack | DROP req low, awaiting ack low | WAIT toggle sent, awaiting echo
module cdc_pulse_src_ch
  import cdc_pkg::*;
#(
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pulse_i,
  input  logic             ack_i,
  input  logic             ovf_clr_i,
  output logic             req_o,
  output logic             busy_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] pend_o
);

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(cnt_max(CNT_W));

  ch_state_e              state;
  logic                   req;
  logic                   ovf;
  logic [CNT_W-1:0]       pend;
  logic [CNT_W-1:0]       pend_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   launch;
  logic                   pend_full;
  logic                   lost;

  always_ff @(posedge clk_i) begin
    if (rst_i) ack_sync <= '0;
    else       ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
  end

  assign ack_s     = ack_sync[SYNC_STAGES-1];
  assign launch    = (state == IDLE) && (pend != '0);
  assign pend_full = (pend == PEND_MAX);
  // A launch frees one slot, so a pulse at full count with launch is still accepted.
  assign lost      = pulse_i && !launch && pend_full;

  always_comb begin
    pend_nxt = pend;
    unique case ({pulse_i, launch})
      2'b10:   pend_nxt = pend_full ? pend : pend + 1'b1;
      2'b01:   pend_nxt = pend - 1'b1;
      default: pend_nxt = pend;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      ovf  <= lost | (ovf & ~ovf_clr_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      req   <= 1'b0;
    end else begin
      case (state)
`ifdef CDC_PULSE_TOGGLE_EN
        IDLE: begin
          if (launch) begin
            req   <= ~req;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (ack_s == req) state <= IDLE;
        end
        default: state <= IDLE;
`else
        IDLE: begin
          if (launch) begin
            req   <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            req   <= 1'b0;
            state <= DROP;
          end
        end
        DROP: begin
          if (!ack_s) state <= IDLE;
        end
        default: begin
          req   <= 1'b0;
          state <= IDLE;
        end
`endif
      endcase
    end
  end

  assign req_o  = req;
  assign ovf_o  = ovf;
  assign pend_o = pend;
  assign busy_o = (pend != '0) | (state != IDLE);

endmodule

// File: rtl/cdc_pulse_src_mc.sv
// Multi-channel pulse source controller; CDC_PULSE_TOGGLE_EN selects the 2-phase toggle handshake.
module cdc_pulse_src_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       pulse_i,
  output logic [NUM_CH-1:0]       req_o,
  input  logic [NUM_CH-1:0]       ack_i,
  output logic [NUM_CH-1:0]       busy_o,
  output logic [NUM_CH-1:0]       ovf_o,
  input  logic [NUM_CH-1:0]       ovf_clr_i,
  output logic [NUM_CH*CNT_W-1:0] pend_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    cdc_pulse_src_ch #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .pulse_i  (pulse_i[c]),
      .ack_i    (ack_i[c]),
      .ovf_clr_i(ovf_clr_i[c]),
      .req_o    (req_o[c]),
      .busy_o   (busy_o[c]),
      .ovf_o    (ovf_o[c]),
      .pend_o   (pend_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_cdc_pulse_src_mc.sv
// Directed bench for cdc_pulse_src_mc with a 5-cycle req echo acting as the destination side.
module tb_cdc_pulse_src_mc;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 3;
  localparam int SYNC_STAGES = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       pulse;
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       ovf_clr;
  logic [NUM_CH*CNT_W-1:0] pend;

  logic [NUM_CH-1:0] ack_en;
  logic [4:0]        hist [NUM_CH] = '{default: '0};
  logic [NUM_CH-1:0] req_prev = '0;
  int                rise_cnt [NUM_CH] = '{default: 0};
  int                tog_cnt  [NUM_CH] = '{default: 0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cdc_pulse_src_mc #(
    .NUM_CH     (NUM_CH),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .pulse_i  (pulse),
    .req_o    (req),
    .ack_i    (ack),
    .busy_o   (busy),
    .ovf_o    (ovf),
    .ovf_clr_i(ovf_clr),
    .pend_o   (pend)
  );

  // Destination model: ack follows req five cycles later, optionally forced low.
  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) hist[c] <= {hist[c][3:0], req[c]};
  end

  always_comb begin
    ack = '0;
    for (int c = 0; c < NUM_CH; c++) ack[c] = hist[c][4] & ack_en[c];
  end

  always @(negedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (req[c] && !req_prev[c]) rise_cnt[c] <= rise_cnt[c] + 1;
      if (req[c] != req_prev[c])  tog_cnt[c]  <= tog_cnt[c] + 1;
    end
    req_prev <= req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pend_of(input int ch);
    return int'((pend >> (ch * CNT_W)) & {CNT_W{1'b1}});
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int ch, input int bound, input string tag, output int peak);
    int n;
    n    = 0;
    peak = pend_of(ch);
    while (busy[ch] && n < bound) begin
      tick();
      if (pend_of(ch) > peak) peak = pend_of(ch);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < bound), 32'd1);
  endtask

  initial begin
    int base;
    int peak;

    rst     = 1'b1;
    pulse   = '0;
    ovf_clr = '0;
    ack_en  = '1;
    tick();
    tick();
    check("rst_req",  32'(req),  32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    rst = 1'b0;
    tick();

`ifdef CDC_PULSE_TOGGLE_EN
    base  = tog_cnt[0];
    pulse = 4'b0001;
    tick();
    tick();
    check("tg_first_toggle", 32'(req[0]), 32'd1);
    tick();
    tick();
    pulse = '0;
    check("tg_pend3", 32'(pend_of(0)), 32'd3);
    wait_idle(0, 200, "tg_drain", peak);
    check("tg_toggles", 32'(tog_cnt[0] - base), 32'd4);
    check("tg_req_end", 32'(req[0]), 32'd0);
    check("tg_ovf",     32'(ovf[0]), 32'd0);
`else
    // Single transfer on ch0: exact latencies through the handshake.
    pulse = 4'b0001;
    tick();
    pulse = '0;
    check("t1_pend1",     32'(pend_of(0)), 32'd1);
    check("t1_req_early", 32'(req[0]),     32'd0);
    tick();
    check("t1_req_rise",  32'(req[0]),     32'd1);
    check("t1_pend0",     32'(pend_of(0)), 32'd0);
    repeat (4) tick();
    check("t1_ack_low",   32'(ack[0]),     32'd0);
    tick();
    check("t1_ack_high",  32'(ack[0]),     32'd1);
    tick();
    tick();
    check("t1_req_still", 32'(req[0]),     32'd1);
    tick();
    check("t1_req_fall",  32'(req[0]),     32'd0);
    check("t1_busy_drop", 32'(busy[0]),    32'd1);
    repeat (7) tick();
    check("t1_busy_hold", 32'(busy[0]),    32'd1);
    tick();
    check("t1_busy_clr",  32'(busy[0]),    32'd0);
    check("t1_pend_end",  32'(pend_of(0)), 32'd0);

    // Burst of three on ch1.
    base  = rise_cnt[1];
    pulse = 4'b0010;
    tick();
    check("t2_pend_a", 32'(pend_of(1)), 32'd1);
    tick();
    check("t2_pend_b", 32'(pend_of(1)), 32'd1);
    tick();
    pulse = '0;
    check("t2_pend_c", 32'(pend_of(1)), 32'd2);
    wait_idle(1, 200, "t2_drain", peak);
    check("t2_peak",  32'(peak),                32'd2);
    check("t2_rises", 32'(rise_cnt[1] - base),  32'd3);
    check("t2_ovf",   32'(ovf[1]),              32'd0);

    // Saturation on ch2 with ack held low.
    ack_en[2] = 1'b0;
    pulse     = 4'b0100;
    repeat (8) tick();
    check("t3_pend_max", 32'(pend_of(2)), 32'd7);
    check("t3_ovf_pre",  32'(ovf[2]),     32'd0);
    tick();
    check("t3_pend_sat", 32'(pend_of(2)), 32'd7);
    check("t3_ovf_set",  32'(ovf[2]),     32'd1);
    ovf_clr = 4'b0100;
    tick();
    check("t3_set_wins", 32'(ovf[2]),     32'd1);
    pulse = '0;
    tick();
    check("t3_clr",      32'(ovf[2]),     32'd0);
    ovf_clr = '0;
    repeat (3) tick();
    check("t3_ovf_stays", 32'(ovf[2]),    32'd0);
    check("t3_req_held",  32'(req[2]),    32'd1);
    ack_en[2] = 1'b1;
    wait_idle(2, 400, "t3_drain", peak);
    check("t3_ovf_end",   32'(ovf[2]),    32'd0);

    // Pulse coinciding with the launch cycle on ch0.
    base  = rise_cnt[0];
    pulse = 4'b0001;
    tick();
    check("t4_pend1", 32'(pend_of(0)), 32'd1);
    check("t4_req0",  32'(req[0]),     32'd0);
    tick();
    pulse = '0;
    check("t4_coinc_pend", 32'(pend_of(0)), 32'd1);
    check("t4_coinc_req",  32'(req[0]),     32'd1);
    wait_idle(0, 200, "t4_drain", peak);
    check("t4_rises", 32'(rise_cnt[0] - base), 32'd2);

    // Reset while ch3 sits in REQ with two pending.
    ack_en[3] = 1'b0;
    base      = rise_cnt[3];
    pulse     = 4'b1000;
    tick();
    tick();
    tick();
    pulse = '0;
    check("t5_req_pre",  32'(req[3]),     32'd1);
    check("t5_pend_pre", 32'(pend_of(3)), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_req_rst",  32'(req),  32'd0);
    check("t5_pend_rst", 32'(pend), 32'd0);
    check("t5_busy_rst", 32'(busy), 32'd0);
    repeat (10) tick();
    check("t5_req_quiet",  32'(req),                 32'd0);
    check("t5_busy_quiet", 32'(busy),                32'd0);
    check("t5_rises",      32'(rise_cnt[3] - base),  32'd1);
    ack_en[3] = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
